// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: control inputs, instruction-memory port and IF/ID outputs.
//   master : fetch_unit side (drives pc, imem_addr, IF/ID register and decoded register fields)
//   slave  : environment side (drives stall/flush/redirects, answers imem reads)
interface fetch_if #(
  parameter int PC_W   = 16,
  parameter int INST_W = 16,
  parameter int OFF_W  = 6
);
  logic              stall;
  logic              flush;
  logic              branch_en;
  logic [OFF_W-1:0]  branch_off;
  logic              jump_en;
  logic [PC_W-1:0]   jump_target;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] instruction;
  logic [PC_W-1:0]   inst_pc;
  logic              valid;
  logic [2:0]        read1_addr;
  logic [2:0]        read2_addr;
  logic [2:0]        write_addr;
  logic [PC_W-1:0]   fetch_count;

  modport master (
    input  stall, flush, branch_en, branch_off, jump_en, jump_target, imem_rdata,
    output imem_addr, pc, instruction, inst_pc, valid,
           read1_addr, read2_addr, write_addr, fetch_count
  );

  modport slave (
    output stall, flush, branch_en, branch_off, jump_en, jump_target, imem_rdata,
    input  imem_addr, pc, instruction, inst_pc, valid,
           read1_addr, read2_addr, write_addr, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with jump/branch/sequential next-PC selection,
// combinational instruction-memory address, and the IF/ID pipeline register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears pc, IF/ID register and fetch_count)
//   bus  : fetch_if.master -- stall/flush/redirect controls in, imem read port,
//          pc / instruction / inst_pc / valid / register fields / fetch_count out
module fetch_unit #(
  parameter int PC_W       = 16,
  parameter int INST_W     = 16,
  parameter int OFF_W      = 6,
  parameter bit SIGNED_OFF = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  logic [PC_W-1:0]   pc_q, pc_nxt, off_ext, ipc_q, cnt_q;
  logic [INST_W-1:0] inst_q;
  logic              vld_q;

  // Offset widened to PC_W; wrap-around of the add gives modulo-2^PC_W behaviour.
  assign off_ext = SIGNED_OFF ? {{(PC_W-OFF_W){bus.branch_off[OFF_W-1]}}, bus.branch_off}
                              : {{(PC_W-OFF_W){1'b0}}, bus.branch_off};

  // Redirects win over stall; stall only freezes the sequential advance.
  always_comb begin
    pc_nxt = pc_q + 1'b1;
    if (bus.jump_en)        pc_nxt = bus.jump_target;
    else if (bus.branch_en) pc_nxt = pc_q + off_ext;
    else if (bus.stall)     pc_nxt = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      inst_q <= '0;
      ipc_q  <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q <= pc_nxt;
      // Flush squashes the capture regardless of stall; inst_pc is left stale.
      if (bus.flush) begin
        inst_q <= '0;
        vld_q  <= 1'b0;
      end else if (!bus.stall) begin
        inst_q <= bus.imem_rdata;
        ipc_q  <= pc_q;
        vld_q  <= 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = inst_q;
  assign bus.inst_pc     = ipc_q;
  assign bus.valid       = vld_q;
  assign bus.fetch_count = cnt_q;
  assign bus.read1_addr  = inst_q[8:6];
  assign bus.read2_addr  = inst_q[5:3];
  assign bus.write_addr  = inst_q[11:9];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Two instances share stimulus: [0] sign-extends offsets, [1] zero-extends.
  fetch_if #(.PC_W(16), .INST_W(16), .OFF_W(6)) bs0 ();
  fetch_if #(.PC_W(16), .INST_W(16), .OFF_W(6)) bs1 ();

  fetch_unit #(.PC_W(16), .INST_W(16), .OFF_W(6), .SIGNED_OFF(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bs0));
  fetch_unit #(.PC_W(16), .INST_W(16), .OFF_W(6), .SIGNED_OFF(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bs1));

  function automatic logic [15:0] mem(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  assign bs0.imem_rdata = mem(bs0.imem_addr);
  assign bs1.imem_rdata = mem(bs1.imem_addr);

  // Stimulus (identical for both instances)
  logic       st, fl, be, je;
  logic [5:0] bo;
  logic [15:0] jt;
  always_comb begin
    bs0.stall = st; bs0.flush = fl; bs0.branch_en = be; bs0.branch_off = bo;
    bs0.jump_en = je; bs0.jump_target = jt;
    bs1.stall = st; bs1.flush = fl; bs1.branch_en = be; bs1.branch_off = bo;
    bs1.jump_en = je; bs1.jump_target = jt;
  end

  // Behavioural model: architectural state per instance, updated from the rules.
  int m_pc[2], m_inst[2], m_ipc[2], m_vld[2], m_cnt[2];
  initial for (int k = 0; k < 2; k++) begin
    m_pc[k] = 0; m_inst[k] = 0; m_ipc[k] = 0; m_vld[k] = 0; m_cnt[k] = 0;
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] <= 0; m_inst[k] <= 0; m_ipc[k] <= 0; m_vld[k] <= 0; m_cnt[k] <= 0;
      end else begin
        int off;
        off = int'(bo);
        if (k == 0 && off >= 32) off = off - 64;
        if (je)      m_pc[k] <= int'(jt);
        else if (be) m_pc[k] <= (m_pc[k] + off + 65536) % 65536;
        else if (!st) m_pc[k] <= (m_pc[k] + 1) % 65536;
        if (fl) begin
          m_inst[k] <= 0; m_vld[k] <= 0;
        end else if (!st) begin
          m_inst[k] <= int'(mem(16'(m_pc[k])));
          m_ipc[k]  <= m_pc[k];
          m_vld[k]  <= 1;
          m_cnt[k]  <= (m_cnt[k] + 1) % 65536;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int k, input logic [15:0] pc, input logic [15:0] ia,
                         input logic [15:0] ins, input logic [15:0] ipc, input logic v,
                         input logic [15:0] cnt, input logic [2:0] r1, input logic [2:0] r2,
                         input logic [2:0] w);
    logic [15:0] mi;
    mi = 16'(m_inst[k]);
    chk($sformatf("pc[%0d]", k), 32'(pc), 32'(m_pc[k]));
    chk($sformatf("imem_addr[%0d]", k), 32'(ia), 32'(m_pc[k]));
    chk($sformatf("instruction[%0d]", k), 32'(ins), 32'(m_inst[k]));
    chk($sformatf("inst_pc[%0d]", k), 32'(ipc), 32'(m_ipc[k]));
    chk($sformatf("valid[%0d]", k), 32'(v), 32'(m_vld[k]));
    chk($sformatf("fetch_count[%0d]", k), 32'(cnt), 32'(m_cnt[k]));
    chk($sformatf("read1[%0d]", k), 32'(r1), 32'(mi[8:6]));
    chk($sformatf("read2[%0d]", k), 32'(r2), 32'(mi[5:3]));
    chk($sformatf("write[%0d]", k), 32'(w), 32'(mi[11:9]));
  endtask

  // Compare process: every falling edge, both instances against the model.
  bit cmp_on = 1'b0;
  always @(negedge clk) if (cmp_on) begin
    cmp_one(0, bs0.pc, bs0.imem_addr, bs0.instruction, bs0.inst_pc, bs0.valid,
            bs0.fetch_count, bs0.read1_addr, bs0.read2_addr, bs0.write_addr);
    cmp_one(1, bs1.pc, bs1.imem_addr, bs1.instruction, bs1.inst_pc, bs1.valid,
            bs1.fetch_count, bs1.read1_addr, bs1.read2_addr, bs1.write_addr);
  end

  task automatic idle();
    st = 0; fl = 0; be = 0; je = 0; bo = '0; jt = '0;
  endtask

  task automatic edge_();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic go(input logic s, input logic f, input logic b, input logic [5:0] o,
                    input logic j, input logic [15:0] t);
    st = s; fl = f; be = b; bo = o; je = j; jt = t;
    edge_();
    idle();
  endtask

  logic [15:0] sv_pc, sv_ins, sv_cnt, sv_ipc;

  initial begin
    idle();
    #1 rst = 1'b1;
    // Inputs toggled under reset must have no effect.
    st = 1; je = 1; jt = 16'h1234; be = 1; bo = 6'h3f;
    @(negedge clk); cmp_on = 1'b1;
    @(negedge clk); #1;
    chk("reset_pc", 32'(bs0.pc), 0);
    chk("reset_valid", 32'(bs0.valid), 0);
    chk("reset_count", 32'(bs0.fetch_count), 0);
    idle();
    rst = 1'b0;

    // Sequential fetch, 4 edges
    repeat (4) edge_();
    chk("seq_pc", 32'(bs0.pc), 4);
    chk("seq_inst", 32'(bs0.instruction), 32'h1003);
    chk("seq_ipc", 32'(bs0.inst_pc), 3);
    chk("seq_valid", 32'(bs0.valid), 1);
    chk("seq_count", 32'(bs0.fetch_count), 4);

    // Branch -4 from pc=10: signed -> 6, unsigned -> 70
    go(0, 1, 0, '0, 1, 16'd10);
    go(0, 0, 1, 6'b111100, 0, '0);
    chk("br_signed_pc", 32'(bs0.pc), 6);
    chk("br_unsigned_pc", 32'(bs1.pc), 70);

    // Jump beats branch; flush squashes
    go(0, 1, 0, '0, 1, 16'd5);
    go(0, 1, 1, 6'd3, 1, 16'h0100);
    chk("jmp_pc", 32'(bs0.pc), 32'h0100);
    chk("jmp_valid", 32'(bs0.valid), 0);
    chk("jmp_inst", 32'(bs0.instruction), 0);
    edge_();
    chk("jmp_next_ipc", 32'(bs0.inst_pc), 32'h0100);
    chk("jmp_next_valid", 32'(bs0.valid), 1);
    chk("jmp_next_inst", 32'(bs0.instruction), 32'h1100);

    // Stall hold, then redirect under stall
    sv_pc = bs0.pc; sv_ins = bs0.instruction; sv_cnt = bs0.fetch_count; sv_ipc = bs0.inst_pc;
    st = 1; repeat (3) edge_(); idle();
    chk("stall_pc", 32'(bs0.pc), 32'(sv_pc));
    chk("stall_inst", 32'(bs0.instruction), 32'(sv_ins));
    chk("stall_count", 32'(bs0.fetch_count), 32'(sv_cnt));
    go(1, 0, 1, 6'd2, 0, '0);
    chk("stall_br_pc", 32'(bs0.pc), 32'(sv_pc + 16'd2));
    chk("stall_br_inst", 32'(bs0.instruction), 32'(sv_ins));
    chk("stall_br_ipc", 32'(bs0.inst_pc), 32'(sv_ipc));
    chk("stall_br_count", 32'(bs0.fetch_count), 32'(sv_cnt));

    // Wrap cases
    go(0, 1, 0, '0, 1, 16'hFFFF);
    edge_();
    chk("wrap_seq_pc", 32'(bs0.pc), 0);
    chk("wrap_seq_ipc", 32'(bs0.inst_pc), 32'hFFFF);
    go(0, 1, 0, '0, 1, 16'h0001);
    go(0, 0, 1, 6'b111110, 0, '0);
    chk("wrap_br_pc", 32'(bs0.pc), 32'hFFFF);
    chk("wrap_br_unsigned_pc", 32'(bs1.pc), 63);

    // Async reset between edges while valid=1
    edge_();
    chk("pre_rst_valid", 32'(bs0.valid), 1);
    @(posedge clk); #2;
    st = 1; je = 1; jt = 16'h4444;
    rst = 1'b1;
    #1;
    chk("arst_pc", 32'(bs0.pc), 0);
    chk("arst_inst", 32'(bs0.instruction), 0);
    chk("arst_ipc", 32'(bs0.inst_pc), 0);
    chk("arst_valid", 32'(bs0.valid), 0);
    chk("arst_count", 32'(bs0.fetch_count), 0);
    chk("arst_fields", 32'({bs0.read1_addr, bs0.read2_addr, bs0.write_addr}), 0);
    @(negedge clk); #1;
    idle(); rst = 1'b0;
    edge_();
    chk("post_rst_pc", 32'(bs0.pc), 1);
    chk("post_rst_inst", 32'(bs0.instruction), 32'h1000);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 15);
      be = ($urandom_range(0, 99) < 20);
      je = ($urandom_range(0, 99) < 10);
      bo = 6'($urandom);
      jt = 16'($urandom);
      if (i % 151 == 75) begin
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
      end else begin
        edge_();
      end
    end
    idle();
    edge_();
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
